// File: rtl/control_unit.sv
// Instruction decoder: {mode, opcode, S} is decoded combinationally and registered with one cycle of latency.
// Optional `illegal` output port is added when CU_ILLEGAL_FLAG_EN is defined.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic [3:0] opcode,
    input  logic       S,
    output logic       S_UpdateSig,
    output logic       branch,
    output logic [3:0] exeCMD,
    output logic       memWriteEn,
    output logic       memReadEn,
    output logic       WB_EN
`ifdef CU_ILLEGAL_FLAG_EN
    ,
    output logic       illegal
`endif
);

    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    logic       legal_next;
    logic       s_update_dec;
    logic       branch_dec;
    logic [3:0] exe_cmd_dec;
    logic       mem_write_dec;
    logic       mem_read_dec;
    logic       wb_en_dec;

    logic       s_update_next;
    logic       branch_next;
    logic [3:0] exe_cmd_next;
    logic       mem_write_next;
    logic       mem_read_next;
    logic       wb_en_next;

    always_comb begin
        legal_next    = 1'b0;
        s_update_dec  = 1'b0;
        branch_dec    = 1'b0;
        exe_cmd_dec   = CMD_NOP;
        mem_write_dec = 1'b0;
        mem_read_dec  = 1'b0;
        wb_en_dec     = 1'b0;

        unique case (mode)
            MODE_DP: begin
                legal_next   = 1'b1;
                s_update_dec = S;
                wb_en_dec    = 1'b1;
                unique case (opcode)
                    OP_MOV: exe_cmd_dec = CMD_MOV;
                    OP_MVN: exe_cmd_dec = CMD_MVN;
                    OP_ADD: exe_cmd_dec = CMD_ADD;
                    OP_ADC: exe_cmd_dec = CMD_ADC;
                    OP_SUB: exe_cmd_dec = CMD_SUB;
                    OP_SBC: exe_cmd_dec = CMD_SBC;
                    OP_AND: exe_cmd_dec = CMD_AND;
                    OP_ORR: exe_cmd_dec = CMD_ORR;
                    OP_EOR: exe_cmd_dec = CMD_EOR;
                    // Compares only set flags; the result is discarded.
                    OP_CMP: begin
                        exe_cmd_dec  = CMD_SUB;
                        s_update_dec = 1'b1;
                        wb_en_dec    = 1'b0;
                    end
                    OP_TST: begin
                        exe_cmd_dec  = CMD_AND;
                        s_update_dec = 1'b1;
                        wb_en_dec    = 1'b0;
                    end
                    default: legal_next = 1'b0;
                endcase
            end
            MODE_MEM: begin
                if (opcode == OP_ADD) begin
                    legal_next    = 1'b1;
                    exe_cmd_dec   = CMD_ADD;
                    mem_read_dec  = S;
                    mem_write_dec = ~S;
                    wb_en_dec     = S;
                end
            end
            MODE_BR: begin
                legal_next = 1'b1;
                branch_dec = 1'b1;
            end
            default: legal_next = 1'b0;
        endcase
    end

    // Masking with the legality flag guarantees all-zero outputs for undefined encodings.
    always_comb begin
        s_update_next  = s_update_dec  & legal_next;
        branch_next    = branch_dec    & legal_next;
        exe_cmd_next   = exe_cmd_dec   & {4{legal_next}};
        mem_write_next = mem_write_dec & legal_next;
        mem_read_next  = mem_read_dec  & legal_next;
        wb_en_next     = wb_en_dec     & legal_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S_UpdateSig <= 1'b0;
            branch      <= 1'b0;
            exeCMD      <= CMD_NOP;
            memWriteEn  <= 1'b0;
            memReadEn   <= 1'b0;
            WB_EN       <= 1'b0;
        end else begin
            S_UpdateSig <= s_update_next;
            branch      <= branch_next;
            exeCMD      <= exe_cmd_next;
            memWriteEn  <= mem_write_next;
            memReadEn   <= mem_read_next;
            WB_EN       <= wb_en_next;
        end
    end

`ifdef CU_ILLEGAL_FLAG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal <= 1'b0;
        end else begin
            illegal <= ~legal_next;
        end
    end
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: expected decodes are queued when inputs are driven
// and popped one cycle later when the registered outputs are sampled.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic [3:0] opcode;
    logic       S;
    logic       S_UpdateSig;
    logic       branch;
    logic [3:0] exeCMD;
    logic       memWriteEn;
    logic       memReadEn;
    logic       WB_EN;
    logic       ill_obs;

    int checks = 0;
    int errors = 0;

    // Layout: {illegal, S_UpdateSig, branch, exeCMD[3:0], memWriteEn, memReadEn, WB_EN}
    logic [9:0] exp_q[$];
    logic [9:0] obs;
    logic [9:0] exp_v;

`ifdef CU_ILLEGAL_FLAG_EN
    logic illegal;
    localparam logic [9:0] MASK = 10'h3FF;
    assign ill_obs = illegal;
`else
    localparam logic [9:0] MASK = 10'h1FF;
    assign ill_obs = 1'b0;
`endif

    assign obs = {ill_obs, S_UpdateSig, branch, exeCMD, memWriteEn, memReadEn, WB_EN};

    control_unit dut (
        .clk(clk),
        .rst(rst),
        .mode(mode),
        .opcode(opcode),
        .S(S),
        .S_UpdateSig(S_UpdateSig),
        .branch(branch),
        .exeCMD(exeCMD),
        .memWriteEn(memWriteEn),
        .memReadEn(memReadEn),
`ifdef CU_ILLEGAL_FLAG_EN
        .illegal(illegal),
`endif
        .WB_EN(WB_EN)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [9:0] mk(input logic ill, input logic su, input logic br,
                                      input logic [3:0] exe, input logic mw,
                                      input logic mr, input logic wb);
        return {ill, su, br, exe, mw, mr, wb};
    endfunction

    function automatic logic [9:0] model(input logic [1:0] m, input logic [3:0] o, input logic s);
        logic [9:0] r;
        r = mk(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        if (m == 2'b00) begin
            case (o)
                4'b1101: r = mk(0, s, 0, 4'b0001, 0, 0, 1);
                4'b1111: r = mk(0, s, 0, 4'b1001, 0, 0, 1);
                4'b0100: r = mk(0, s, 0, 4'b0010, 0, 0, 1);
                4'b0101: r = mk(0, s, 0, 4'b0011, 0, 0, 1);
                4'b0010: r = mk(0, s, 0, 4'b0100, 0, 0, 1);
                4'b0110: r = mk(0, s, 0, 4'b0101, 0, 0, 1);
                4'b0000: r = mk(0, s, 0, 4'b0110, 0, 0, 1);
                4'b1100: r = mk(0, s, 0, 4'b0111, 0, 0, 1);
                4'b0001: r = mk(0, s, 0, 4'b1000, 0, 0, 1);
                4'b1010: r = mk(0, 1, 0, 4'b0100, 0, 0, 0);
                4'b1000: r = mk(0, 1, 0, 4'b0110, 0, 0, 0);
                default: ;
            endcase
        end else if (m == 2'b01 && o == 4'b0100) begin
            r = s ? mk(0, 0, 0, 4'b0010, 0, 1, 1) : mk(0, 0, 0, 4'b0010, 1, 0, 0);
        end else if (m == 2'b10) begin
            r = mk(0, 0, 1, 4'b0000, 0, 0, 0);
        end
        return r & MASK;
    endfunction

    // Drive on the falling edge, queue the expectation, then land 1 time unit after the rising edge.
    task automatic drive(input logic [1:0] m, input logic [3:0] o, input logic s);
        @(negedge clk);
        mode = m;
        opcode = o;
        S = s;
        exp_q.push_back(model(m, o, s));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ((obs & MASK) !== 10'h000) begin
            errors++;
            $display("FAIL reset_hold: got=%h expected=%h", obs & MASK, 10'h000);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(model(2'b10, 4'b0000, 1'b0));
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if ((obs & MASK) !== exp_v) begin
            errors++;
            $display("FAIL reset_release_branch: got=%h expected=%h", obs & MASK, exp_v);
        end
        // Assert reset between edges: outputs must clear without waiting for a clock.
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ((obs & MASK) !== 10'h000) begin
            errors++;
            $display("FAIL reset_async: got=%h expected=%h", obs & MASK, 10'h000);
        end
        #1;
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_data_proc;
        drive(2'b00, 4'b1101, 1'b1);
        exp_v = exp_q.pop_front();
        checks++;
        if ((obs & MASK) !== exp_v) begin
            errors++;
            $display("FAIL dp_mov_s1: got=%h expected=%h", obs & MASK, exp_v);
        end
        drive(2'b00, 4'b0010, 1'b0);
        exp_v = exp_q.pop_front();
        checks++;
        if ((obs & MASK) !== exp_v) begin
            errors++;
            $display("FAIL dp_sub_s0: got=%h expected=%h", obs & MASK, exp_v);
        end
        $display("test_data_proc done");
    endtask

    task automatic test_compare;
        drive(2'b00, 4'b1010, 1'b0);
        exp_v = exp_q.pop_front();
        checks++;
        if ((obs & MASK) !== exp_v) begin
            errors++;
            $display("FAIL cmp_s0: got=%h expected=%h", obs & MASK, exp_v);
        end
        drive(2'b00, 4'b0011, 1'b1);
        exp_v = exp_q.pop_front();
        checks++;
        if ((obs & MASK) !== exp_v) begin
            errors++;
            $display("FAIL dp_undefined_0011: got=%h expected=%h", obs & MASK, exp_v);
        end
        $display("test_compare done");
    endtask

    task automatic test_memory;
        drive(2'b01, 4'b0100, 1'b1);
        exp_v = exp_q.pop_front();
        checks++;
        if ((obs & MASK) !== exp_v) begin
            errors++;
            $display("FAIL mem_ldr: got=%h expected=%h", obs & MASK, exp_v);
        end
        drive(2'b01, 4'b0100, 1'b0);
        exp_v = exp_q.pop_front();
        checks++;
        if ((obs & MASK) !== exp_v) begin
            errors++;
            $display("FAIL mem_str: got=%h expected=%h", obs & MASK, exp_v);
        end
        $display("test_memory done");
    endtask

    task automatic test_branch;
        drive(2'b10, 4'b0000, 1'b0);
        exp_v = exp_q.pop_front();
        checks++;
        if ((obs & MASK) !== exp_v) begin
            errors++;
            $display("FAIL branch: got=%h expected=%h", obs & MASK, exp_v);
        end
        drive(2'b11, 4'b0100, 1'b1);
        exp_v = exp_q.pop_front();
        checks++;
        if ((obs & MASK) !== exp_v) begin
            errors++;
            $display("FAIL mode11_undefined: got=%h expected=%h", obs & MASK, exp_v);
        end
        $display("test_branch done");
    endtask

    // Back-to-back sweep: a new combination every cycle, each checked one cycle later.
    task automatic test_sweep;
        for (int i = 0; i < 128; i++) begin
            logic [6:0] v;
            v = i[6:0];
            drive(v[6:5], v[4:1], v[0]);
            exp_v = exp_q.pop_front();
            checks++;
            if ((obs & MASK) !== exp_v) begin
                errors++;
                $display("FAIL sweep mode=%b opcode=%b S=%b: got=%h expected=%h",
                         v[6:5], v[4:1], v[0], obs & MASK, exp_v);
            end
            checks++;
            if ((memReadEn & memWriteEn) !== 1'b0 ||
                (branch & (WB_EN | memReadEn | memWriteEn)) !== 1'b0) begin
                errors++;
                $display("FAIL invariant mode=%b opcode=%b S=%b: got=%h expected exclusive enables",
                         v[6:5], v[4:1], v[0], obs & MASK);
            end
        end
        $display("test_sweep done: 128 combinations");
    endtask

    task automatic test_mid_reset;
        @(negedge clk);
        mode = 2'b00;
        opcode = 4'b1101;
        S = 1'b1;
        exp_q.push_back(model(2'b00, 4'b1101, 1'b1));
        #2;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        checks++;
        if ((obs & MASK) !== 10'h000) begin
            errors++;
            $display("FAIL mid_reset_discard: got=%h expected=%h", obs & MASK, 10'h000);
        end
        @(negedge clk);
        rst = 1'b0;
        mode = 2'b00;
        opcode = 4'b0100;
        S = 1'b0;
        exp_q.push_back(model(2'b00, 4'b0100, 1'b0));
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        checks++;
        if ((obs & MASK) !== exp_v) begin
            errors++;
            $display("FAIL mid_reset_first_decode: got=%h expected=%h", obs & MASK, exp_v);
        end
        $display("test_mid_reset done");
    endtask

    initial begin
        rst = 1'b1;
        mode = 2'b10;
        opcode = 4'b0000;
        S = 1'b0;
        test_reset();
        test_data_proc();
        test_compare();
        test_memory();
        test_branch();
        test_sweep();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
